// File: rtl/ser_word_deser.sv
// Bit-serial to parallel word assembler feeding a single-entry valid/ready holding register.
// Latency: par_valid rises on the edge that captures the final bit of a word (one cycle after it is presented).
// Backpressure: holding register stalls while par_ready=0; a word completing while it is FULL is dropped and sets sticky overrun.
module ser_word_deser #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  hold_state_t      state_q;
  hold_state_t      state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seeded;
  logic [CNT_W-1:0] cnt_d;
  logic             last_bit;
  logic             word_done;
  logic             load_word;
  logic             drop_word;

  // Candidate shift-register values: normal shift, and a fresh word seeded with the current bit.
  always_comb begin
    shifted = shift_q;
    seeded  = '0;
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], bit_in};
      seeded  = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin
      shifted = {bit_in, shift_q[WIDTH-1:1]};
      seeded  = {bit_in, {(WIDTH-1){1'b0}}};
    end
  end

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  // Shift path: alignment marker wins over completion; gaps leave state untouched.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = bit_cnt;
    word_done = 1'b0;
    if (frame_start) begin
      if (bit_valid) begin
        shift_d = seeded;
        cnt_d   = CNT_W'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (bit_valid) begin
      shift_d = shifted;
      if (last_bit) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = bit_cnt + CNT_W'(1);
      end
    end
  end

  // Holding register next state: load when free or draining, drop when stalled.
  always_comb begin
    state_d   = state_q;
    load_word = 1'b0;
    drop_word = 1'b0;
    case (state_q)
      HOLD_EMPTY: begin
        if (word_done) begin
          load_word = 1'b1;
          state_d   = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (par_ready) begin
          if (word_done) begin
            load_word = 1'b1;
          end else begin
            state_d = HOLD_EMPTY;
          end
        end else if (word_done) begin
          drop_word = 1'b1;
        end
      end
      default: state_d = HOLD_EMPTY;
    endcase
  end

  // State registers; par_out keeps its last word after it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt <= '0;
      state_q <= HOLD_EMPTY;
      par_out <= '0;
      overrun <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bit_cnt <= cnt_d;
      state_q <= state_d;
      if (load_word) begin
        par_out <= shift_d;
      end
      if (drop_word) begin
        overrun <= 1'b1;
      end
    end
  end

  assign par_valid = (state_q == HOLD_FULL);

endmodule

// File: tb/tb_ser_word_deser.sv
module tb_ser_word_deser;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          par_ready = 1'b1;
  logic [W-1:0]  po_m, po_l;
  logic          pv_m, pv_l, ov_m, ov_l;
  logic [CW-1:0] bc_m, bc_l;

  always #5 clk = ~clk;

  ser_word_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .par_out(po_m), .par_valid(pv_m),
    .par_ready(par_ready), .overrun(ov_m), .bit_cnt(bc_m)
  );

  ser_word_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .par_out(po_l), .par_valid(pv_l),
    .par_ready(par_ready), .overrun(ov_l), .bit_cnt(bc_l)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bits of the current word in arrival order, and the holding slot.
  bit           m_bits[W];
  int           m_cnt = 0;
  logic [W-1:0] m_word_m = '0;
  logic [W-1:0] m_word_l = '0;
  bit           m_valid = 1'b0;
  bit           m_ovr = 1'b0;
  bit           m_init = 1'b0;
  bit           m_done;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_cnt    = 0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_word_m = '0;
      m_word_l = '0;
      m_init   = 1'b1;
    end else begin
      if (frame_start) begin
        if (bit_valid) begin
          m_bits[0] = bit_in;
          m_cnt     = 1;
        end else begin
          m_cnt = 0;
        end
      end else if (bit_valid) begin
        m_bits[m_cnt] = bit_in;
        m_cnt++;
        if (m_cnt == W) begin
          m_done = 1'b1;
          m_cnt  = 0;
        end
      end
      if (m_done) begin
        if (!m_valid || par_ready) begin
          for (int i = 0; i < W; i++) begin
            m_word_m[W-1-i] = m_bits[i];
            m_word_l[i]     = m_bits[i];
          end
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && par_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("par_out_msb",   32'(po_m), 32'(m_word_m));
      chk("par_out_lsb",   32'(po_l), 32'(m_word_l));
      chk("par_valid_msb", 32'(pv_m), 32'(m_valid));
      chk("par_valid_lsb", 32'(pv_l), 32'(m_valid));
      chk("overrun_msb",   32'(ov_m), 32'(m_ovr));
      chk("overrun_lsb",   32'(ov_l), 32'(m_ovr));
      chk("bit_cnt_msb",   32'(bc_m), 32'(m_cnt));
      chk("bit_cnt_lsb",   32'(bc_l), 32'(m_cnt));
    end
  end

  // Log of words actually handed over by the MSB-first instance.
  logic [W-1:0] hs_q[$];
  always @(posedge clk) begin
    if (!rst && pv_m === 1'b1 && par_ready === 1'b1) hs_q.push_back(po_m);
  end

  task automatic drive(input logic v, input logic b, input logic fs);
    @(negedge clk);
    bit_valid   = v;
    bit_in      = b;
    frame_start = fs;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_msb(input logic [W-1:0] w, input bit fs_first, input int maxgap);
    for (int i = 0; i < W; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) idle();
      drive(1'b1, w[W-1-i], fs_first && (i == 0));
    end
  endtask

  function automatic logic [31:0] hs_last();
    if (hs_q.size() == 0) return 32'hDEAD_BEEF;
    return 32'(hs_q[hs_q.size()-1]);
  endfunction

  logic [W-1:0] w_tmp;

  initial begin
    // Reset held two edges with bit_valid/frame_start active.
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; bit_in = 1'b0;
    chk("rst_par_out",   32'(po_m), 32'h0);
    chk("rst_par_valid", 32'(pv_m), 32'h0);
    chk("rst_overrun",   32'(ov_m), 32'h0);
    chk("rst_bit_cnt",   32'(bc_m), 32'h0);

    // Single contiguous word with frame_start on the first bit.
    par_ready = 1'b1;
    send_msb(16'hA50F, 1'b1, 0);
    idle();
    chk("single_par_out",   32'(po_m), 32'h0000A50F);
    chk("single_valid_hi",  32'(pv_m), 32'h1);
    chk("single_bit_cnt",   32'(bc_m), 32'h0);
    chk("model_word_msb",   32'(m_word_m), 32'h0000A50F);
    chk("model_word_lsb",   32'(m_word_l), 32'h0000F0A5);
    idle();
    chk("single_valid_lo",  32'(pv_m), 32'h0);
    chk("single_hs_count",  32'(hs_q.size()), 32'd1);
    chk("single_hs_word",   hs_last(), 32'h0000A50F);

    // Gapped word, then back-to-back word.
    send_msb(16'hA50F, 1'b0, 2);
    send_msb(16'hFFFF, 1'b0, 0);
    idle(); idle();
    chk("gap_hs_count", 32'(hs_q.size()), 32'd3);
    chk("gap_hs_1", 32'(hs_q[1]), 32'h0000A50F);
    chk("gap_hs_2", 32'(hs_q[2]), 32'h0000FFFF);

    // Held word drained on the same edge a new word completes.
    par_ready = 1'b0;
    send_msb(16'h1234, 1'b0, 0);
    w_tmp = 16'h00FF;
    for (int i = 0; i < W - 1; i++) drive(1'b1, w_tmp[W-1-i], 1'b0);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = w_tmp[0]; frame_start = 1'b0; par_ready = 1'b1;
    idle();
    chk("swap_par_out", 32'(po_m), 32'h000000FF);
    chk("swap_valid",   32'(pv_m), 32'h1);
    chk("swap_overrun", 32'(ov_m), 32'h0);
    chk("swap_hs_word", hs_last(), 32'h00001234);
    idle();
    chk("swap_drained", 32'(pv_m), 32'h0);
    chk("swap_hs_count", 32'(hs_q.size()), 32'd5);

    // Back-pressure: second word lost, sticky overrun.
    par_ready = 1'b0;
    send_msb(16'h1234, 1'b0, 0);
    send_msb(16'h00FF, 1'b0, 0);
    idle();
    chk("bp_par_out", 32'(po_m), 32'h00001234);
    chk("bp_valid",   32'(pv_m), 32'h1);
    chk("bp_overrun", 32'(ov_m), 32'h1);
    par_ready = 1'b1;
    idle();
    par_ready = 1'b0;
    idle();
    chk("bp_hs_word",   hs_last(), 32'h00001234);
    chk("bp_hs_count",  32'(hs_q.size()), 32'd6);
    chk("bp_valid_lo",  32'(pv_m), 32'h0);
    chk("bp_ovr_stays", 32'(ov_m), 32'h1);

    // Resync: stray bits discarded by frame_start.
    par_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b0);
    send_msb(16'hA50F, 1'b1, 0);
    idle();
    chk("resync_par_out", 32'(po_m), 32'h0000A50F);
    idle();
    chk("resync_hs_count", 32'(hs_q.size()), 32'd7);

    // frame_start on what would be the final bit: no completion.
    for (int i = 0; i < W - 1; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    idle();
    chk("fs_last_bit_cnt", 32'(bc_m), 32'h1);
    chk("fs_last_no_word", 32'(pv_m), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    idle();
    chk("fs_novalid_cnt", 32'(bc_m), 32'h0);

    // Reset in the middle of a word.
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0;
    chk("midrst_overrun", 32'(ov_m), 32'h0);
    chk("midrst_bit_cnt", 32'(bc_m), 32'h0);
    send_msb(16'h3C5A, 1'b0, 0);
    idle(); idle();
    chk("midrst_hs_count", 32'(hs_q.size()), 32'd8);
    chk("midrst_hs_word",  hs_last(), 32'h00003C5A);

    // LSB-first ordering.
    w_tmp = 16'hA50F;
    for (int i = 0; i < W; i++) drive(1'b1, w_tmp[i], 1'b0);
    idle();
    chk("lsb_par_out",      32'(po_l), 32'h0000A50F);
    chk("lsb_valid",        32'(pv_l), 32'h1);
    chk("lsb_msb_inst_out", 32'(po_m), 32'h0000F0A5);
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ser_word_deser.md
Name: ser_word_deser

Overview:
- Bit-serial to parallel word assembler. It sits directly upstream of the 16-bit ones-counter stage and supplies its in_s word.
- Collects WIDTH serial bits qualified by bit_valid and realigns on frame_start.
- Presents each complete word through a single-entry holding register with a valid/ready handshake.
- Flags words lost to back-pressure with a sticky overrun bit.

Parameters:
- WIDTH, 16, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in par_out[WIDTH-1]; 0 = first bit lands in par_out[0].

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled on this edge when high.
- frame_start  input  1  word alignment marker; see Behaviour.
- par_out  output  WIDTH  assembled word; connects to the popcount stage's in_s.
- par_valid  output  1  par_out holds an unconsumed word.
- par_ready  input  1  consumer accepts par_out on an edge where par_valid && par_ready.
- overrun  output  1  sticky: a completed word was dropped.
- bit_cnt  output  clog2(WIDTH)  bits collected toward the current word.

Behaviour:
- Reset: synchronous and active-high. Sampled at a clk edge with rst=1, it sets par_out=0, par_valid=0, overrun=0, bit_cnt=0, shift register=0 and holding state=EMPTY. Reset overrides every other input on that edge. A partial word in progress at reset is discarded.
- Shift path:
  - On an edge with bit_valid=1, bit_in enters the shift register.
  - MSB_FIRST=1: shift left, insert at bit 0.
  - MSB_FIRST=0: shift right, insert at bit WIDTH-1.
  - bit_cnt increments. bit_valid=0 holds the shift register and bit_cnt unchanged, so gaps of any length are legal.
- Word completion:
  - A word completes on the edge where bit_valid=1 and bit_cnt=WIDTH-1.
  - The word is the shift register contents including that final bit.
  - bit_cnt wraps to 0 on the same edge.
- frame_start with bit_valid=1: the current bit is bit 0 of a new word. Any partial word is discarded, the shift register is cleared except for the new bit, and bit_cnt becomes 1. No completion occurs on that edge, even if bit_cnt was WIDTH-1.
- frame_start with bit_valid=0: bit_cnt becomes 0 and the shift register is cleared.
- Holding register FSM, two states:
  - EMPTY (par_valid=0). On completion: load par_out, go to FULL.
  - FULL (par_valid=1). par_out and par_valid are held stable while par_ready=0.
    - par_ready=1 and no completion: go to EMPTY, par_valid=0 on the next cycle. par_out keeps its last value.
    - par_ready=1 with a simultaneous completion: load the new word, stay FULL, par_valid remains 1. No overrun.
    - par_ready=0 with a completion: the new word is dropped, overrun is set to 1, and par_out is unchanged.
- Latency: par_valid rises on the same edge that captures the final bit, so it is visible in the cycle after the final bit is presented. Sustained throughput is one word per WIDTH valid bits, with no bubbles, when par_ready is held high.
- overrun: cleared only by rst.
- par_ready while EMPTY: ignored.

Test Plan:
- Reset check: assert rst for 2 cycles, with bit_valid=1 and frame_start=1 toggled during reset -> par_out=16'h0000, par_valid=0, overrun=0 and bit_cnt=0 after reset.
- Single word, MSB_FIRST=1, par_ready=1: pulse frame_start with the first bit, then send 16'hA50F MSB-first as contiguous bits (1010 0101 0000 1111) -> par_out=16'hA50F, par_valid high for exactly 1 cycle, the cycle after the 16th bit; bit_cnt returns to 0.
- Gapped bits and back-to-back words: send 16'hA50F with random bit_valid gaps, then 16'hFFFF immediately after, with par_ready=1 -> two handshakes with values A50F then FFFF, and no cycle where par_valid=0 between them if the second word's last bit coincides with the drain.
- Back-pressure: par_ready=0, send 16'h1234 then 16'h00FF -> par_out stays 16'h1234 with par_valid=1 and overrun=1; raise par_ready -> one handshake of 16'h1234, after which par_valid=0 and overrun stays 1.
- Resync: send 5 bits, then frame_start with bit_valid, then 16'hA50F -> par_out=16'hA50F with the 5 stray bits discarded. Separately, assert rst after 9 bits of a word -> no word is emitted and the next 16 bits form a clean word.
- MSB_FIRST=0: send 16'hA50F LSB-first (1111 0000 1010 0101) -> par_out=16'hA50F.
